// File: rtl/key_event_decoder.sv
// key_event_decoder
//   Classifies debounced activity on four keys into SHORT, LONG and DOUBLE
//   click events. It arbitrates the events into a 4-entry FIFO and presents
//   them on a valid/ready interface.
//
// Ports
//   clk        system clock
//   rst_n      synchronous reset, active-high (1 = reset) despite the name
//   key_flag   per-key one-cycle pulse when a debounced edge is confirmed
//   key_state  per-key debounced level (0 = pressed, 1 = released)
//   ev_valid   FIFO holds at least one event
//   ev_ready   consumer accepts the head entry
//   ev_key     key index of the head entry
//   ev_type    head event type (1 = SHORT, 2 = LONG, 3 = DOUBLE)
//   overflow   sticky flag: an event was overwritten before it was queued
//
// Per-key FSM states
//   state    | meaning
//   S_IDLE   | key released, no activity pending
//   S_PRESS  | first press held, counting ticks toward LONG
//   S_HOLD   | LONG already issued, waiting for release
//   S_WAIT   | short release seen, double-click window running
//   S_PRESS2 | second press inside the window, DOUBLE on release
module key_event_decoder #(
  parameter int TICK_DIV = 50000,
  parameter int LONG_MS  = 1000,
  parameter int DBL_MS   = 300
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_flag,
  input  logic [3:0] key_state,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_key,
  output logic [1:0] ev_type,
  output logic       overflow
);

  localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] EV_SHORT  = 2'd1;
  localparam logic [1:0] EV_LONG   = 2'd2;
  localparam logic [1:0] EV_DOUBLE = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_PRESS, S_HOLD, S_WAIT, S_PRESS2} state_t;

  // timebase
  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst_n)     pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else           pre_cnt <= pre_cnt + 1'b1;
  end

  // per-key FSMs
  logic [3:0]       prs, rel;
  state_t           state [4];
  state_t           state_nxt [4];
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] cnt_nxt [4];
  logic [3:0]       emit;
  logic [1:0]       emit_type [4];

  assign prs = key_flag & ~key_state;
  assign rel = key_flag &  key_state;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end else begin
        state[i] <= state_nxt[i];
        cnt[i]   <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_nxt[i] = state[i];
      cnt_nxt[i]   = cnt[i];
      case (state[i])
        S_IDLE: begin
          if (prs[i]) begin
            state_nxt[i] = S_PRESS;
            cnt_nxt[i]   = '0;
          end
        end
        S_PRESS: begin
          // release takes priority over a coincident long expiry
          if (rel[i]) begin
            state_nxt[i] = S_WAIT;
            cnt_nxt[i]   = '0;
          end else if (tick) begin
            if (cnt[i] == CNT_W'(LONG_MS - 1)) state_nxt[i] = S_HOLD;
            else if (cnt[i] != '1)             cnt_nxt[i]   = cnt[i] + 1'b1;
          end
        end
        S_HOLD: begin
          if (rel[i]) state_nxt[i] = S_IDLE;
        end
        S_WAIT: begin
          // a second press takes priority over a coincident window timeout
          if (prs[i]) begin
            state_nxt[i] = S_PRESS2;
          end else if (tick) begin
            if (cnt[i] == CNT_W'(DBL_MS - 1)) state_nxt[i] = S_IDLE;
            else if (cnt[i] != '1)            cnt_nxt[i]   = cnt[i] + 1'b1;
          end
        end
        S_PRESS2: begin
          if (rel[i]) state_nxt[i] = S_IDLE;
        end
        default: state_nxt[i] = S_IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      emit[i]      = 1'b0;
      emit_type[i] = 2'd0;
      case (state[i])
        S_PRESS: begin
          if (!rel[i] && tick && cnt[i] == CNT_W'(LONG_MS - 1)) begin
            emit[i]      = 1'b1;
            emit_type[i] = EV_LONG;
          end
        end
        S_WAIT: begin
          if (!prs[i] && tick && cnt[i] == CNT_W'(DBL_MS - 1)) begin
            emit[i]      = 1'b1;
            emit_type[i] = EV_SHORT;
          end
        end
        S_PRESS2: begin
          if (rel[i]) begin
            emit[i]      = 1'b1;
            emit_type[i] = EV_DOUBLE;
          end
        end
        default: ;
      endcase
    end
  end

  // pending slots and arbiter
  logic [3:0] slot_valid;
  logic [1:0] slot_type [4];
  logic [1:0] grant;
  logic       push, pop;
  logic [2:0] fifo_cnt;

  always_comb begin
    grant = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (slot_valid[i]) grant = 2'(i);
    end
  end

  assign push = (|slot_valid) && (fifo_cnt < 3'd4);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      slot_valid <= '0;
      overflow   <= 1'b0;
      for (int i = 0; i < 4; i++) slot_type[i] <= 2'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (emit[i]) begin
          slot_valid[i] <= 1'b1;
          slot_type[i]  <= emit_type[i];
          // draining in the same cycle frees the slot, so nothing is lost
          if (slot_valid[i] && !(push && grant == 2'(i))) overflow <= 1'b1;
        end else if (push && grant == 2'(i)) begin
          slot_valid[i] <= 1'b0;
        end
      end
    end
  end

  // event FIFO, entry = {key, type}
  logic [3:0] fifo_mem [4];
  logic [1:0] wr_ptr, rd_ptr;

  assign ev_valid = (fifo_cnt != 3'd0);
  assign pop      = ev_valid & ev_ready;
  assign ev_key   = fifo_mem[rd_ptr][3:2];
  assign ev_type  = fifo_mem[rd_ptr][1:0];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
      for (int i = 0; i < 4; i++) fifo_mem[i] <= 4'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {grant, slot_type[grant]};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_key_event_decoder.sv
// tb_key_event_decoder
//   Directed bench for key_event_decoder with TICK_DIV = 4, LONG_MS = 10,
//   DBL_MS = 5. The bench keeps its own copy of the 1-in-4 tick phase so
//   that event cycles can be predicted independently of the design.
module tb_key_event_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] key_flag;
  logic [3:0] key_state;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_key;
  logic [1:0] ev_type;
  logic       overflow;

  int passed = 0;
  int total  = 0;

  localparam logic [1:0] SHORT  = 2'd1;
  localparam logic [1:0] LONG   = 2'd2;
  localparam logic [1:0] DOUBLE = 2'd3;

  key_event_decoder #(.TICK_DIV(4), .LONG_MS(10), .DBL_MS(5)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_flag (key_flag),
    .key_state(key_state),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_key   (ev_key),
    .ev_type  (ev_type),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // tick phase reference: tick is due in the current cycle when tb_pre == 3
  int tb_pre = 0;
  always @(posedge clk) begin
    if (rst_n)            tb_pre <= 0;
    else if (tb_pre == 3) tb_pre <= 0;
    else                  tb_pre <= tb_pre + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] mask, input logic lvl);
    for (int i = 0; i < 4; i++) if (mask[i]) key_state[i] = lvl;
    key_flag = mask;
    cycle();
    key_flag = 4'd0;
  endtask

  // advance through n ticks; returns whether ev_valid was seen on the way
  task automatic run_ticks(input int n, output bit seen);
    int t;
    t = 0;
    seen = 1'b0;
    while (t < n) begin
      if (ev_valid) seen = 1'b1;
      if (tb_pre == 3) t++;
      cycle();
    end
  endtask

  task automatic run_quiet(input int n, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (ev_valid) seen = 1'b1;
      cycle();
    end
  endtask

  task automatic to_tick();
    while (tb_pre != 3) cycle();
  endtask

  // press, release, press, release on one key: DOUBLE emitted in the last cycle
  task automatic dbl(input int k);
    logic [3:0] m;
    m = 4'd1 << k;
    pulse(m, 1'b0);
    cycle();
    pulse(m, 1'b1);
    cycle();
    pulse(m, 1'b0);
    cycle();
    pulse(m, 1'b1);
  endtask

  task automatic pop_one();
    ev_ready = 1'b1;
    cycle();
    ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_flag  = (i % 2 == 0) ? 4'hF : 4'h5;
      key_state = (i % 2 == 0) ? 4'h0 : 4'hF;
      cycle();
    end
    total++; if (ev_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ev_valid); else passed++;
    total++; if (ev_key !== 2'd0)   $display("FAIL reset_key got %0d want 0", ev_key); else passed++;
    total++; if (ev_type !== 2'd0)  $display("FAIL reset_type got %0d want 0", ev_type); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b want 0", overflow); else passed++;
    key_flag  = 4'd0;
    key_state = 4'hF;
    rst_n     = 1'b0;
    cycle();
    total++; if (ev_valid !== 1'b0) $display("FAIL reset_release_valid got %b want 0", ev_valid); else passed++;
  endtask

  task automatic test_short();
    bit seen;
    pulse(4'b0001, 1'b0);
    run_ticks(3, seen);
    pulse(4'b0001, 1'b1);
    run_ticks(5, seen);
    total++; if (seen) $display("FAIL short_early got valid want none"); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL short_latency1 got %b want 0", ev_valid); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1) $display("FAIL short_valid got %b want 1", ev_valid); else passed++;
    total++; if (ev_key !== 2'd0 || ev_type !== SHORT)
      $display("FAIL short_entry got key %0d type %0d want key 0 type 1", ev_key, ev_type); else passed++;
    pop_one();
    total++; if (ev_valid !== 1'b0) $display("FAIL short_pop got %b want 0", ev_valid); else passed++;
  endtask

  task automatic test_long();
    bit seen;
    pulse(4'b0001, 1'b0);
    run_ticks(10, seen);
    total++; if (seen) $display("FAIL long_early got valid want none"); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL long_latency1 got %b want 0", ev_valid); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== LONG)
      $display("FAIL long_entry got v %b key %0d type %0d want v 1 key 0 type 2", ev_valid, ev_key, ev_type); else passed++;
    pop_one();
    run_ticks(2, seen);
    pulse(4'b0001, 1'b1);
    run_quiet(60, seen);
    total++; if (seen) $display("FAIL long_release got event want none"); else passed++;
  endtask

  task automatic test_double();
    bit seen;
    dbl(0);
    total++; if (ev_valid !== 1'b0) $display("FAIL double_latency1 got %b want 0", ev_valid); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== DOUBLE)
      $display("FAIL double_entry got v %b key %0d type %0d want v 1 key 0 type 3", ev_valid, ev_key, ev_type); else passed++;
    pop_one();
    run_quiet(40, seen);
    total++; if (seen) $display("FAIL double_extra got event want none"); else passed++;
  endtask

  task automatic test_release_at_long();
    bit seen;
    pulse(4'b0001, 1'b0);
    run_ticks(9, seen);
    to_tick();
    pulse(4'b0001, 1'b1);
    run_ticks(5, seen);
    total++; if (seen) $display("FAIL bnd_long_no_long got event want none"); else passed++;
    total++; if (ev_valid !== 1'b0) $display("FAIL bnd_long_latency1 got %b want 0", ev_valid); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== SHORT)
      $display("FAIL bnd_long_short got v %b key %0d type %0d want v 1 key 0 type 1", ev_valid, ev_key, ev_type); else passed++;
    pop_one();
  endtask

  task automatic test_press_at_timeout();
    bit seen;
    pulse(4'b0001, 1'b0);
    cycle();
    pulse(4'b0001, 1'b1);
    run_ticks(4, seen);
    to_tick();
    pulse(4'b0001, 1'b0);
    pulse(4'b0001, 1'b1);
    total++; if (ev_valid !== 1'b0) $display("FAIL bnd_dbl_no_short got %b want 0", ev_valid); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== DOUBLE)
      $display("FAIL bnd_dbl_entry got v %b key %0d type %0d want v 1 key 0 type 3", ev_valid, ev_key, ev_type); else passed++;
    pop_one();
    run_quiet(40, seen);
    total++; if (seen) $display("FAIL bnd_dbl_extra got event want none"); else passed++;
  endtask

  task automatic test_simultaneous();
    bit seen;
    ev_ready = 1'b1;
    pulse(4'b1011, 1'b0);
    cycle();
    pulse(4'b1011, 1'b1);
    run_ticks(5, seen);
    total++; if (seen || ev_valid !== 1'b0) $display("FAIL sim_early got valid want none"); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== SHORT)
      $display("FAIL sim_first got v %b key %0d type %0d want v 1 key 0 type 1", ev_valid, ev_key, ev_type); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd1 || ev_type !== SHORT)
      $display("FAIL sim_second got v %b key %0d type %0d want v 1 key 1 type 1", ev_valid, ev_key, ev_type); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd3 || ev_type !== SHORT)
      $display("FAIL sim_third got v %b key %0d type %0d want v 1 key 3 type 1", ev_valid, ev_key, ev_type); else passed++;
    cycle();
    total++; if (ev_valid !== 1'b0) $display("FAIL sim_empty got %b want 0", ev_valid); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL sim_overflow got %b want 0", overflow); else passed++;
    ev_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    bit seen;
    logic [1:0] ek [6];
    logic [1:0] et [6];
    ev_ready = 1'b0;
    dbl(0); dbl(1); dbl(2); dbl(3); dbl(0); dbl(1);
    cycle();
    cycle();
    total++; if (ev_valid !== 1'b1 || ev_key !== 2'd0 || ev_type !== DOUBLE)
      $display("FAIL bp_head got v %b key %0d type %0d want v 1 key 0 type 3", ev_valid, ev_key, ev_type); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL bp_no_overflow got %b want 0", overflow); else passed++;
    // key 0 slot still waits with DOUBLE; a SHORT on key 0 replaces it
    pulse(4'b0001, 1'b0);
    cycle();
    pulse(4'b0001, 1'b1);
    run_ticks(5, seen);
    total++; if (overflow !== 1'b1) $display("FAIL bp_overflow got %b want 1", overflow); else passed++;
    ek[0] = 2'd0; et[0] = DOUBLE;
    ek[1] = 2'd1; et[1] = DOUBLE;
    ek[2] = 2'd2; et[2] = DOUBLE;
    ek[3] = 2'd3; et[3] = DOUBLE;
    ek[4] = 2'd0; et[4] = SHORT;
    ek[5] = 2'd1; et[5] = DOUBLE;
    ev_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      total++;
      if (ev_valid !== 1'b1 || ev_key !== ek[i] || ev_type !== et[i])
        $display("FAIL bp_drain%0d got v %b key %0d type %0d want v 1 key %0d type %0d",
                 i, ev_valid, ev_key, ev_type, ek[i], et[i]);
      else passed++;
      cycle();
    end
    total++; if (ev_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", ev_valid); else passed++;
    total++; if (overflow !== 1'b1) $display("FAIL bp_sticky got %b want 1", overflow); else passed++;
    ev_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit seen;
    ev_ready = 1'b0;
    dbl(0);
    dbl(1);
    cycle();
    cycle();
    total++; if (ev_valid !== 1'b1) $display("FAIL mid_prefill got %b want 1", ev_valid); else passed++;
    pulse(4'b0100, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    rst_n = 1'b0;
    total++; if (ev_valid !== 1'b0) $display("FAIL mid_valid got %b want 0", ev_valid); else passed++;
    total++; if (ev_key !== 2'd0 || ev_type !== 2'd0)
      $display("FAIL mid_fields got key %0d type %0d want 0 0", ev_key, ev_type); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL mid_overflow got %b want 0", overflow); else passed++;
    pulse(4'b0100, 1'b1);
    run_quiet(60, seen);
    total++; if (seen) $display("FAIL mid_release got event want none"); else passed++;
  endtask

  initial begin
    rst_n     = 1'b1;
    key_flag  = 4'd0;
    key_state = 4'hF;
    ev_ready  = 1'b0;
    test_reset();
    test_short();
    test_long();
    test_double();
    test_release_at_long();
    test_press_at_timeout();
    test_simultaneous();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
